// File: rtl/accelerator_trainer_differentiation_pkg.sv
// accelerator_trainer_differentiation_pkg: shared state encoding and data-width constants for the differentiation controller
package accelerator_trainer_differentiation_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, RUN, WAIT, DONE} state_t;
  localparam int DATA_SIZE_DEFAULT = 64;
  localparam logic [DATA_SIZE_DEFAULT-1:0] DATA_ZERO = '0;
  localparam logic [DATA_SIZE_DEFAULT-1:0] DATA_ONE = DATA_SIZE_DEFAULT'(1);
endpackage

// File: rtl/accelerator_trainer_differentiation_matrix_counter.sv
// accelerator_trainer_differentiation_matrix_counter: row/column element counter with wrap and first/last flags
module accelerator_trainer_differentiation_matrix_counter #(
  parameter int DATA_SIZE = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 step,
  input  logic [DATA_SIZE-1:0] rows,
  input  logic [DATA_SIZE-1:0] cols,
  output logic                 first_col,
  output logic                 last_col,
  output logic                 last
);
  localparam logic [DATA_SIZE-1:0] DONE_ONE = DATA_SIZE'(1);
  localparam logic [CONTROL_SIZE-1:0] CNT_ONE = CONTROL_SIZE'(1);
  logic [CONTROL_SIZE-1:0] i, j;
  always_comb begin
    first_col = j == '0;
    last_col = j == CONTROL_SIZE'(cols - DONE_ONE);
    last = last_col && i == CONTROL_SIZE'(rows - DONE_ONE);
  end
  // the final element wraps both indices, so the next matrix starts at (0,0)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      i <= '0;
      j <= '0;
    end else if (clear) begin
      i <= '0;
      j <= '0;
    end else if (step) begin
      j <= last_col ? '0 : j + CNT_ONE;
      i <= last ? '0 : (last_col ? i + CNT_ONE : i);
    end
endmodule

// File: rtl/accelerator_trainer_differentiation_controller.sv
// accelerator_trainer_differentiation_controller: loads W/B into the FNN datapath, starts it and reports completion.
// Define ACCELERATOR_TRAINER_DIFFERENTIATION_TIMEOUT_EN to add the WAIT watchdog and the ERROR output.
module accelerator_trainer_differentiation_controller
  import accelerator_trainer_differentiation_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_L_IN,
  input  logic [DATA_SIZE-1:0] SIZE_X_IN,
  input  logic                 SRC_VALID,
  input  logic [DATA_SIZE-1:0] SRC_DATA,
  output logic                 SRC_READY,
  output logic                 FNN_START,
  input  logic                 FNN_READY,
  output logic                 FNN_W_IN_L_ENABLE,
  output logic                 FNN_W_IN_X_ENABLE,
  output logic [DATA_SIZE-1:0] FNN_W_IN,
  output logic                 FNN_B_IN_ENABLE,
  output logic [DATA_SIZE-1:0] FNN_B_IN,
  output logic [DATA_SIZE-1:0] FNN_SIZE_L_IN,
  output logic [DATA_SIZE-1:0] FNN_SIZE_X_IN,
`ifdef ACCELERATOR_TRAINER_DIFFERENTIATION_TIMEOUT_EN
  output logic                 ERROR,
`endif
  output logic                 BUSY
);
  state_t state, nxt;
  logic [DATA_SIZE-1:0] size_l, size_x, cols;
  logic xfer, drain, first_col, last_col, last, timeout;
  assign xfer = SRC_VALID && SRC_READY;
  assign cols = state == LOAD_W ? size_x : DATA_SIZE'(DATA_ONE);
  assign FNN_SIZE_L_IN = size_l;
  assign FNN_SIZE_X_IN = size_x;
  accelerator_trainer_differentiation_matrix_counter #(
    .DATA_SIZE(DATA_SIZE),
    .CONTROL_SIZE(CONTROL_SIZE)
  ) u_cnt (
    .clk(CLK),
    .rst(RST),
    .clear(state == IDLE),
    .step(xfer),
    .rows(size_l),
    .cols(cols),
    .first_col(first_col),
    .last_col(last_col),
    .last(last)
  );
`ifdef ACCELERATOR_TRAINER_DIFFERENTIATION_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd;
  assign timeout = wd == WDW'(TIMEOUT_CYCLES - 1);
  // counter sits at zero outside WAIT, so each WAIT visit starts a fresh window
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wd <= '0;
      ERROR <= 1'b0;
    end else begin
      wd <= state == WAIT ? wd + WDW'(1) : '0;
      ERROR <= state == WAIT && !FNN_READY && timeout;
    end
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !START ? IDLE : SIZE_L_IN == '0 ? RUN : SIZE_X_IN == '0 ? LOAD_B : LOAD_W;
      LOAD_W:  nxt = xfer && last ? LOAD_B : LOAD_W;
      LOAD_B:  nxt = drain ? RUN : LOAD_B;
      RUN:     nxt = WAIT;
      WAIT:    nxt = FNN_READY || timeout ? DONE : WAIT;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    READY = state == DONE;
    BUSY = state != IDLE;
    SRC_READY = (state == LOAD_W || state == LOAD_B) && !drain;
    FNN_START = state == RUN;
  end
  // drain holds LOAD_B for one idle cycle so the last B strobe never meets FNN_START
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      size_l <= DATA_SIZE'(DATA_ZERO);
      size_x <= DATA_SIZE'(DATA_ZERO);
      drain <= 1'b0;
      FNN_W_IN_L_ENABLE <= 1'b0;
      FNN_W_IN_X_ENABLE <= 1'b0;
      FNN_B_IN_ENABLE <= 1'b0;
      FNN_W_IN <= DATA_SIZE'(DATA_ZERO);
      FNN_B_IN <= DATA_SIZE'(DATA_ZERO);
    end else begin
      if (state == IDLE && START) begin
        size_l <= SIZE_L_IN;
        size_x <= SIZE_X_IN;
      end
      drain <= xfer && state == LOAD_B && last;
      FNN_W_IN_X_ENABLE <= xfer && state == LOAD_W;
      FNN_W_IN_L_ENABLE <= xfer && state == LOAD_W && first_col;
      FNN_B_IN_ENABLE <= xfer && state == LOAD_B;
      if (xfer && state == LOAD_W) FNN_W_IN <= SRC_DATA;
      if (xfer && state == LOAD_B) FNN_B_IN <= SRC_DATA;
    end
endmodule

// File: tb/tb_accelerator_trainer_differentiation_controller.sv
// tb_accelerator_trainer_differentiation_controller: randomized self-checking bench against a stream-level model
module tb_accelerator_trainer_differentiation_controller;
  localparam int DS = 64;
  logic CLK = 1'b0;
  logic RST, START, READY, SRC_VALID, SRC_READY, FNN_START, FNN_READY;
  logic FNN_W_IN_L_ENABLE, FNN_W_IN_X_ENABLE, FNN_B_IN_ENABLE, BUSY;
  logic [DS-1:0] SIZE_L_IN, SIZE_X_IN, SRC_DATA, FNN_W_IN, FNN_B_IN, FNN_SIZE_L_IN, FNN_SIZE_X_IN;
`ifdef ACCELERATOR_TRAINER_DIFFERENTIATION_TIMEOUT_EN
  logic ERROR;
`endif
  int compared = 0, mismatched = 0;
  logic [DS-1:0] sent[$], w_d[$], b_d[$];
  bit w_l[$];
  int start_cnt, start_cyc, ready_cyc, fr_cyc, last_s, bad, overlap, srcrdy_cnt, busy_lo;
  bit err_seen;

  always #5 CLK = ~CLK;

  accelerator_trainer_differentiation_controller #(
    .DATA_SIZE(DS), .CONTROL_SIZE(64), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .SIZE_L_IN(SIZE_L_IN), .SIZE_X_IN(SIZE_X_IN),
    .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA), .SRC_READY(SRC_READY),
    .FNN_START(FNN_START), .FNN_READY(FNN_READY),
    .FNN_W_IN_L_ENABLE(FNN_W_IN_L_ENABLE), .FNN_W_IN_X_ENABLE(FNN_W_IN_X_ENABLE), .FNN_W_IN(FNN_W_IN),
    .FNN_B_IN_ENABLE(FNN_B_IN_ENABLE), .FNN_B_IN(FNN_B_IN),
    .FNN_SIZE_L_IN(FNN_SIZE_L_IN), .FNN_SIZE_X_IN(FNN_SIZE_X_IN),
`ifdef ACCELERATOR_TRAINER_DIFFERENTIATION_TIMEOUT_EN
    .ERROR(ERROR),
`endif
    .BUSY(BUSY)
  );

  // Drives one START..READY sequence and records what the datapath side saw.
  // vm: 0 always valid, 1 valid on even cycles, 2 random; ack<0 never answers FNN_START.
  task automatic run(input int l, input int x, input int vm, input int ack, input bit seq, input bit noise);
    bit prev_xfer = 1'b0;
    logic [DS-1:0] d = DS'(1);
    sent.delete(); w_d.delete(); b_d.delete(); w_l.delete();
    start_cnt = 0; start_cyc = -1; ready_cyc = -1; fr_cyc = -1; last_s = -1;
    bad = 0; overlap = 0; srcrdy_cnt = 0; busy_lo = 0; err_seen = 1'b0;
    @(negedge CLK);
    SIZE_L_IN = DS'(l); SIZE_X_IN = DS'(x); START = 1'b1; SRC_VALID = 1'b0; FNN_READY = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge CLK);
      START = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      FNN_READY = 1'b0;
      if (noise) begin SIZE_L_IN = DS'($urandom); SIZE_X_IN = DS'($urandom); end
      if (!BUSY) busy_lo++;
      if (FNN_W_IN_X_ENABLE) begin w_d.push_back(FNN_W_IN); w_l.push_back(FNN_W_IN_L_ENABLE); last_s = c; end
      else if (FNN_W_IN_L_ENABLE) bad++;
      if (FNN_B_IN_ENABLE) begin b_d.push_back(FNN_B_IN); last_s = c; end
      if ((FNN_W_IN_X_ENABLE || FNN_B_IN_ENABLE) != prev_xfer || (FNN_W_IN_X_ENABLE && FNN_B_IN_ENABLE)) bad++;
      if (FNN_START) begin
        start_cnt++; start_cyc = c;
        if (FNN_W_IN_X_ENABLE || FNN_B_IN_ENABLE) overlap++;
      end
      if (READY) begin
        ready_cyc = c;
`ifdef ACCELERATOR_TRAINER_DIFFERENTIATION_TIMEOUT_EN
        err_seen = ERROR;
`endif
        break;
      end
      SRC_VALID = vm == 0 ? 1'b1 : vm == 1 ? 1'(c % 2 == 0) : 1'($urandom_range(0, 1));
      SRC_DATA = seq ? d : {$urandom, $urandom};
      prev_xfer = SRC_VALID && SRC_READY;
      if (SRC_READY) srcrdy_cnt++;
      if (prev_xfer) begin sent.push_back(SRC_DATA); d++; end
      if (start_cyc > 0 && ack >= 0 && c == start_cyc + 1 + ack) begin FNN_READY = 1'b1; fr_cyc = c; end
      else if (noise && start_cyc < 0) FNN_READY = 1'($urandom_range(0, 1));
    end
    START = 1'b0; SRC_VALID = 1'b0; FNN_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; SRC_VALID = 1'b0; FNN_READY = 1'b0;
    SIZE_L_IN = '0; SIZE_X_IN = '0; SRC_DATA = '0;
    repeat (2) @(negedge CLK);
    compared++;
    if ({READY, SRC_READY, FNN_START, FNN_W_IN_L_ENABLE, FNN_W_IN_X_ENABLE, FNN_B_IN_ENABLE, BUSY, FNN_W_IN, FNN_B_IN, FNN_SIZE_L_IN, FNN_SIZE_X_IN} !== '0) begin
      mismatched++; $display("FAIL reset_held: outputs not all zero (busy=%b w=%0d b=%0d)", BUSY, FNN_W_IN, FNN_B_IN);
    end
    RST = 1'b0;
    @(negedge CLK);
    compared++;
    if ({READY, SRC_READY, FNN_START, FNN_W_IN_X_ENABLE, FNN_B_IN_ENABLE, BUSY} !== 6'b0) begin
      mismatched++; $display("FAIL reset_release: controls=%b expected 000000", {READY, SRC_READY, FNN_START, FNN_W_IN_X_ENABLE, FNN_B_IN_ENABLE, BUSY});
    end
  endtask

  task automatic test_basic();
    run(2, 3, 0, 2, 1'b1, 1'b0);
    compared++;
    if (w_d.size() != 6 || b_d.size() != 2) begin
      mismatched++; $display("FAIL basic_counts: w=%0d b=%0d expected w=6 b=2", w_d.size(), b_d.size());
    end
    for (int k = 0; k < 6 && k < w_d.size(); k++) begin
      compared++;
      if (w_d[k] !== DS'(k + 1) || w_l[k] !== (k % 3 == 0)) begin
        mismatched++; $display("FAIL basic_w%0d: data=%0d l=%b expected data=%0d l=%b", k, w_d[k], w_l[k], k + 1, k % 3 == 0);
      end
    end
    compared++;
    if (b_d.size() == 2 && (b_d[0] !== DS'(7) || b_d[1] !== DS'(8))) begin
      mismatched++; $display("FAIL basic_b: got %0d,%0d expected 7,8", b_d[0], b_d[1]);
    end
    compared++;
    if (start_cnt != 1 || start_cyc != last_s + 1 || overlap != 0 || bad != 0) begin
      mismatched++; $display("FAIL basic_start: count=%0d cyc=%0d last_strobe=%0d overlap=%0d bad=%0d expected 1 at last_strobe+1", start_cnt, start_cyc, last_s, overlap, bad);
    end
    compared++;
    if (fr_cyc < 0 || ready_cyc != fr_cyc + 1) begin
      mismatched++; $display("FAIL basic_ready: ready at %0d expected %0d", ready_cyc, fr_cyc + 1);
    end
  endtask

  task automatic test_toggle();
    int errs = 0;
    run(2, 2, 1, 1, 1'b1, 1'b0);
    compared++;
    if (w_d.size() != 4 || b_d.size() != 2 || bad != 0) begin
      mismatched++; $display("FAIL toggle_counts: w=%0d b=%0d bad=%0d expected 4 2 0", w_d.size(), b_d.size(), bad);
    end
    for (int k = 0; k < w_d.size(); k++) if (w_d[k] !== DS'(k + 1) || w_l[k] !== (k % 2 == 0)) errs++;
    for (int k = 0; k < b_d.size(); k++) if (b_d[k] !== DS'(k + 5)) errs++;
    compared++;
    if (errs != 0 || ready_cyc != fr_cyc + 1) begin
      mismatched++; $display("FAIL toggle_order: %0d wrong elements, ready=%0d expected %0d", errs, ready_cyc, fr_cyc + 1);
    end
  endtask

  task automatic test_zero_sizes();
    run(0, 5, 0, 0, 1'b1, 1'b0);
    compared++;
    if (srcrdy_cnt != 0 || w_d.size() != 0 || b_d.size() != 0) begin
      mismatched++; $display("FAIL zero_l_load: src_ready cycles=%0d w=%0d b=%0d expected 0", srcrdy_cnt, w_d.size(), b_d.size());
    end
    compared++;
    if (start_cyc != 1 || ready_cyc != 3) begin
      mismatched++; $display("FAIL zero_l_latency: start=%0d ready=%0d expected 1 3", start_cyc, ready_cyc);
    end
    run(3, 0, 0, 1, 1'b1, 1'b0);
    compared++;
    if (w_d.size() != 0 || b_d.size() != 3 || bad != 0) begin
      mismatched++; $display("FAIL zero_x_counts: w=%0d b=%0d bad=%0d expected 0 3 0", w_d.size(), b_d.size(), bad);
    end
    compared++;
    if (b_d.size() == 3 && (b_d[0] !== DS'(1) || b_d[2] !== DS'(3) || start_cyc != last_s + 1)) begin
      mismatched++; $display("FAIL zero_x_order: b0=%0d b2=%0d start=%0d expected 1 3 %0d", b_d[0], b_d[2], start_cyc, last_s + 1);
    end
    compared++;
    if (FNN_SIZE_L_IN !== DS'(3) || FNN_SIZE_X_IN !== DS'(0)) begin
      mismatched++; $display("FAIL zero_x_sizes: L=%0d X=%0d expected 3 0", FNN_SIZE_L_IN, FNN_SIZE_X_IN);
    end
  endtask

  task automatic test_reset_mid();
    int junk = 0;
    @(negedge CLK);
    SIZE_L_IN = DS'(2); SIZE_X_IN = DS'(3); START = 1'b1;
    @(negedge CLK);
    START = 1'b0; SRC_VALID = 1'b1; SRC_DATA = DS'(1);
    @(negedge CLK);
    SRC_DATA = DS'(2);
    @(negedge CLK);
    compared++;
    if (FNN_W_IN_X_ENABLE !== 1'b1 || FNN_W_IN !== DS'(2)) begin
      mismatched++; $display("FAIL mid_pre: x_en=%b w=%0d expected 1 2", FNN_W_IN_X_ENABLE, FNN_W_IN);
    end
    #2 RST = 1'b1;
    #1;
    compared++;
    if ({READY, SRC_READY, FNN_START, FNN_W_IN_L_ENABLE, FNN_W_IN_X_ENABLE, FNN_B_IN_ENABLE, BUSY, FNN_W_IN, FNN_B_IN, FNN_SIZE_L_IN, FNN_SIZE_X_IN} !== '0) begin
      mismatched++; $display("FAIL mid_reset: outputs not zero (busy=%b x_en=%b w=%0d L=%0d)", BUSY, FNN_W_IN_X_ENABLE, FNN_W_IN, FNN_SIZE_L_IN);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (FNN_W_IN_X_ENABLE || FNN_W_IN_L_ENABLE || FNN_B_IN_ENABLE || SRC_READY || BUSY) junk++;
    end
    compared++;
    if (junk != 0) begin
      mismatched++; $display("FAIL mid_after: %0d cycles with activity expected 0", junk);
    end
    SRC_VALID = 1'b0;
    run(1, 1, 0, 0, 1'b1, 1'b0);
    compared++;
    if (w_d.size() != 1 || b_d.size() != 1 || ready_cyc != fr_cyc + 1 || fr_cyc < 0) begin
      mismatched++; $display("FAIL mid_restart: w=%0d b=%0d ready=%0d expected 1 1 %0d", w_d.size(), b_d.size(), ready_cyc, fr_cyc + 1);
    end else begin
      compared++;
      if (w_d[0] !== DS'(1) || w_l[0] !== 1'b1 || b_d[0] !== DS'(2)) begin
        mismatched++; $display("FAIL mid_restart_data: w=%0d l=%b b=%0d expected 1 1 2", w_d[0], w_l[0], b_d[0]);
      end
    end
  endtask

  task automatic test_done_start();
    run(1, 0, 0, 0, 1'b1, 1'b0);
    SIZE_L_IN = '0; SIZE_X_IN = '0; START = 1'b1;
    @(negedge CLK);
    compared++;
    if (BUSY !== 1'b0) begin
      mismatched++; $display("FAIL done_start_ignored: busy=%b expected 0", BUSY);
    end
    @(negedge CLK);
    START = 1'b0;
    compared++;
    if (FNN_START !== 1'b1) begin
      mismatched++; $display("FAIL done_start_next: fnn_start=%b expected 1", FNN_START);
    end
    @(negedge CLK);
    FNN_READY = 1'b1;
    @(negedge CLK);
    FNN_READY = 1'b0;
    compared++;
    if (READY !== 1'b1) begin
      mismatched++; $display("FAIL done_start_ready: ready=%b expected 1", READY);
    end
    @(negedge CLK);
    compared++;
    if (READY !== 1'b0 || BUSY !== 1'b0) begin
      mismatched++; $display("FAIL done_start_idle: ready=%b busy=%b expected 0 0", READY, BUSY);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int l = $urandom_range(0, 3);
      int x = $urandom_range(0, 3);
      int errs = 0;
      run(l, x, 2, $urandom_range(0, 5), 1'b0, 1'b1);
      compared++;
      if (sent.size() != l * x + l || w_d.size() != l * x || b_d.size() != l) begin
        mismatched++; $display("FAIL rand_count it=%0d L=%0d X=%0d: sent=%0d w=%0d b=%0d expected %0d %0d %0d", it, l, x, sent.size(), w_d.size(), b_d.size(), l * x + l, l * x, l);
        continue;
      end
      for (int k = 0; k < l * x; k++) if (w_d[k] !== sent[k] || w_l[k] !== (k % x == 0)) errs++;
      for (int k = 0; k < l; k++) if (b_d[k] !== sent[l * x + k]) errs++;
      compared++;
      if (errs != 0) begin
        mismatched++; $display("FAIL rand_order it=%0d: %0d wrong elements expected 0", it, errs);
      end
      compared++;
      if (bad != 0 || busy_lo != 0) begin
        mismatched++; $display("FAIL rand_strobes it=%0d: bad=%0d busy_low=%0d expected 0 0", it, bad, busy_lo);
      end
      compared++;
      if (start_cnt != 1 || overlap != 0 || start_cyc != (l == 0 ? 1 : last_s + 1)) begin
        mismatched++; $display("FAIL rand_start it=%0d: count=%0d cyc=%0d overlap=%0d expected 1 at %0d", it, start_cnt, start_cyc, overlap, l == 0 ? 1 : last_s + 1);
      end
      compared++;
      if (fr_cyc < 0 || ready_cyc != fr_cyc + 1 || FNN_SIZE_L_IN !== DS'(l) || FNN_SIZE_X_IN !== DS'(x)) begin
        mismatched++; $display("FAIL rand_ready it=%0d: ready=%0d L=%0d X=%0d expected %0d %0d %0d", it, ready_cyc, FNN_SIZE_L_IN, FNN_SIZE_X_IN, fr_cyc + 1, l, x);
      end
    end
  endtask

`ifdef ACCELERATOR_TRAINER_DIFFERENTIATION_TIMEOUT_EN
  task automatic test_timeout();
    int junk = 0;
    run(0, 0, 0, -1, 1'b1, 1'b0);
    compared++;
    if (ready_cyc != 18 || err_seen !== 1'b1) begin
      mismatched++; $display("FAIL timeout_pulse: ready=%0d error=%b expected 18 1", ready_cyc, err_seen);
    end
    FNN_READY = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (READY || ERROR || BUSY) junk++;
    end
    FNN_READY = 1'b0;
    compared++;
    if (junk != 0) begin
      mismatched++; $display("FAIL timeout_late_ack: %0d active cycles expected 0", junk);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_zero_sizes();
    test_reset_mid();
    test_done_start();
    test_random();
`ifdef ACCELERATOR_TRAINER_DIFFERENTIATION_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
